// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data-memory port between the core load/store
// port and the program/debug loader. Round-robin on ties, the granted
// transaction is held on the memory port until m_done, and a watchdog aborts
// transactions that never complete.
module data_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstn,
  // core load/store port
  input  logic [31:0] c_addr,
  input  logic [31:0] c_din,
  input  logic [3:0]  c_we,
  input  logic        c_load,
  output logic [31:0] c_dout,
  output logic        c_done,
  // loader port
  input  logic        l_req,
  input  logic [3:0]  l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_done,
  // memory port
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_we,
  output logic        m_load,
  input  logic [31:0] m_rdata,
  input  logic        m_done,
  // sticky watchdog flag
  output logic        err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_C,
    BUSY_L
  } state_t;

  state_t        state, state_nx;
  logic          last_l, last_l_nx;   // 1: loader held the most recent grant
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_nx;
  logic [31:0]   m_addr_nx, m_wdata_nx;
  logic [3:0]    m_we_nx;
  logic          m_load_nx;

  logic c_req;
  logic busy;
  logic tmo;
  logic finish;

  assign c_req  = c_load | (|c_we);
  assign busy   = (state != IDLE);
  // cnt counts completed busy cycles, so it equals TIMEOUT-1 in the
  // TIMEOUT-th busy cycle; a coincident m_done takes priority.
  assign tmo    = busy && !m_done && (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign finish = busy && (m_done || tmo);

  // Completion pulses and read data are routed only to the current owner.
  always_comb begin
    c_done  = 1'b0;
    l_done  = 1'b0;
    c_dout  = '0;
    l_rdata = '0;
    if (finish) begin
      if (state == BUSY_C) begin
        c_done = 1'b1;
        c_dout = m_done ? m_rdata : ERR_DATA;
      end else begin
        l_done  = 1'b1;
        l_rdata = m_done ? m_rdata : ERR_DATA;
      end
    end
  end

  // Grant selection, memory-port capture/release and watchdog next state.
  always_comb begin
    state_nx   = state;
    last_l_nx  = last_l;
    cnt_nx     = cnt;
    err_nx     = err;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    m_we_nx    = m_we;
    m_load_nx  = m_load;
    case (state)
      IDLE: begin
        if (c_req && (!l_req || last_l)) begin
          state_nx   = BUSY_C;
          last_l_nx  = 1'b0;
          cnt_nx     = '0;
          m_addr_nx  = c_addr;
          m_wdata_nx = c_din;
          m_we_nx    = c_we;
          m_load_nx  = c_load & ~(|c_we);
        end else if (l_req) begin
          state_nx   = BUSY_L;
          last_l_nx  = 1'b1;
          cnt_nx     = '0;
          m_addr_nx  = l_addr;
          m_wdata_nx = l_wdata;
          m_we_nx    = l_we;
          m_load_nx  = ~(|l_we);
        end
      end
      BUSY_C, BUSY_L: begin
        if (finish) begin
          state_nx   = IDLE;
          m_addr_nx  = '0;
          m_wdata_nx = '0;
          m_we_nx    = '0;
          m_load_nx  = 1'b0;
          if (!m_done) err_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and memory-port registers; reset drops any transaction at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      last_l  <= 1'b1;
      cnt     <= '0;
      err     <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_we    <= '0;
      m_load  <= 1'b0;
    end else begin
      state   <= state_nx;
      last_l  <= last_l_nx;
      cnt     <= cnt_nx;
      err     <= err_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      m_we    <= m_we_nx;
      m_load  <= m_load_nx;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a transaction-level
// model of the arbiter.
module tb_data_mem_arbiter;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] c_addr, c_din, l_addr, l_wdata, m_rdata;
  logic [3:0]  c_we, l_we;
  logic        c_load, l_req, m_done;
  logic [31:0] c_dout, l_rdata, m_addr, m_wdata;
  logic [3:0]  m_we;
  logic        c_done, l_done, m_load, err;

  data_mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rstn(rstn),
    .c_addr(c_addr), .c_din(c_din), .c_we(c_we), .c_load(c_load),
    .c_dout(c_dout), .c_done(c_done),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_done(l_done),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_load(m_load),
    .m_rdata(m_rdata), .m_done(m_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: who owns the port (0 none, 1 core, 2 loader),
  // the captured request, busy cycles elapsed, who wins the next tie.
  int          mo_owner;
  logic [31:0] mo_addr, mo_wdata;
  logic [3:0]  mo_we;
  logic        mo_load;
  int          mo_age;
  bit          mo_core_next;
  bit          mo_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mo_reset();
    mo_owner = 0; mo_addr = '0; mo_wdata = '0; mo_we = '0; mo_load = 1'b0;
    mo_age = 0; mo_core_next = 1'b1; mo_err = 1'b0;
  endtask

  function automatic bit mo_fin();
    return (mo_owner != 0) && (m_done || (mo_age + 1 == int'(TMO)));
  endfunction

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic mo_step();
    bit creq;
    if (mo_owner != 0) begin
      if (mo_fin()) begin
        if (!m_done) mo_err = 1'b1;
        mo_owner = 0;
      end else begin
        mo_age++;
      end
    end else begin
      creq = c_load || (c_we != 4'h0);
      if (creq && (!l_req || mo_core_next)) begin
        mo_owner = 1; mo_addr = c_addr; mo_wdata = c_din; mo_we = c_we;
        mo_load = c_load && (c_we == 4'h0); mo_core_next = 1'b0; mo_age = 0;
      end else if (l_req) begin
        mo_owner = 2; mo_addr = l_addr; mo_wdata = l_wdata; mo_we = l_we;
        mo_load = (l_we == 4'h0); mo_core_next = 1'b1; mo_age = 0;
      end
    end
  endtask

  // Compare all outputs with the model, mid low phase of the clock.
  task automatic settle();
    bit fin;
    logic [31:0] dat;
    #2;
    if (!rstn) mo_reset();
    fin = mo_fin();
    dat = m_done ? m_rdata : ERR;
    chk("m_addr",  m_addr,  (mo_owner != 0) ? mo_addr  : 32'h0);
    chk("m_wdata", m_wdata, (mo_owner != 0) ? mo_wdata : 32'h0);
    chk("m_we",    m_we,    (mo_owner != 0) ? mo_we    : 4'h0);
    chk("m_load",  m_load,  (mo_owner != 0) ? mo_load  : 1'b0);
    chk("c_done",  c_done,  fin && mo_owner == 1);
    chk("c_dout",  c_dout,  (fin && mo_owner == 1) ? dat : 32'h0);
    chk("l_done",  l_done,  fin && mo_owner == 2);
    chk("l_rdata", l_rdata, (fin && mo_owner == 2) ? dat : 32'h0);
    chk("err",     err,     mo_err);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) mo_step(); else mo_reset();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c_addr = '0; c_din = '0; c_we = '0; c_load = 1'b0;
    l_req = 1'b0; l_we = '0; l_addr = '0; l_wdata = '0;
    m_rdata = '0; m_done = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; settle(); tick();
    rstn = 1'b1;
  endtask

  initial begin
    int thr;
    rstn = 1'b0;
    idle_inputs();
    mo_reset();
    @(negedge clk);

    // reset state
    settle();
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_load", m_load, 1'b0);
    chk("rst_err", err, 1'b0);
    tick();
    rstn = 1'b1; settle(); tick();

    // core read, m_done three cycles after the strobe
    c_load = 1'b1; c_addr = 32'h100;
    settle(); chk("rd_idle_load", m_load, 1'b0); tick();
    c_load = 1'b0; c_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rd_hold_load", m_load, 1'b1);
      chk("rd_hold_addr", m_addr, 32'h100);
      chk("rd_hold_cdone", c_done, 1'b0);
      tick();
    end
    m_done = 1'b1; m_rdata = 32'h1234_5678;
    settle();
    chk("rd_cdone", c_done, 1'b1);
    chk("rd_cdout", c_dout, 32'h1234_5678);
    chk("rd_ldone", l_done, 1'b0);
    tick();
    m_done = 1'b0; m_rdata = '0;
    settle(); chk("rd_after_cdone", c_done, 1'b0); chk("rd_after_load", m_load, 1'b0); tick();

    // core write with c_load also high: write wins
    c_we = 4'b0011; c_load = 1'b1; c_din = 32'hA5A5_1234; c_addr = 32'h200;
    settle(); tick();
    idle_inputs(); m_done = 1'b1;
    settle();
    chk("wr_m_we", m_we, 4'b0011);
    chk("wr_m_load", m_load, 1'b0);
    chk("wr_m_wdata", m_wdata, 32'hA5A5_1234);
    chk("wr_cdone", c_done, 1'b1);
    tick();
    m_done = 1'b0; settle(); tick();

    // continuous contention from reset, single-cycle completions
    do_reset();
    c_load = 1'b1; c_addr = 32'h1000; l_req = 1'b1; l_we = 4'h0; l_addr = 32'h2000;
    m_done = 1'b1; m_rdata = 32'h5555_0000;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("rr_cdone", c_done, (i % 4) == 1);
      chk("rr_ldone", l_done, (i % 4) == 3);
      chk("rr_m_addr", m_addr, ((i % 4) == 1) ? 32'h1000 : ((i % 4) == 3) ? 32'h2000 : 32'h0);
      tick();
    end
    idle_inputs(); settle(); tick();

    // loader write; core raises c_load mid-transaction
    l_req = 1'b1; l_we = 4'hF; l_addr = 32'h300; l_wdata = 32'hCAFE_F00D;
    settle(); tick();
    l_req = 1'b0; l_we = '0; l_addr = '0; l_wdata = '0;
    c_load = 1'b1; c_addr = 32'h400;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("mid_m_addr", m_addr, 32'h300);
      chk("mid_m_we", m_we, 4'hF);
      chk("mid_m_wdata", m_wdata, 32'hCAFE_F00D);
      tick();
    end
    m_done = 1'b1;
    settle(); chk("mid_ldone", l_done, 1'b1); chk("mid_cdone", c_done, 1'b0); tick();
    m_done = 1'b0;
    settle(); chk("mid_idle_we", m_we, 4'h0); tick();
    settle(); chk("mid_core_addr", m_addr, 32'h400); chk("mid_core_load", m_load, 1'b1);
    c_load = 1'b0; c_addr = '0; m_done = 1'b1;
    settle(); tick();
    m_done = 1'b0; settle(); tick();

    // watchdog: loader read never completes
    do_reset();
    l_req = 1'b1; l_addr = 32'h500;
    settle(); tick();
    l_req = 1'b0; l_addr = '0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk("tmo_ldone", l_done, k == 8);
      chk("tmo_lrdata", l_rdata, (k == 8) ? 32'hDEAD_BEEF : 32'h0);
      chk("tmo_err_pre", err, 1'b0);
      tick();
    end
    settle(); chk("tmo_err_set", err, 1'b1); chk("tmo_idle_load", m_load, 1'b0); tick();
    c_load = 1'b1; c_addr = 32'h600;
    settle(); tick();
    c_load = 1'b0; c_addr = '0; m_done = 1'b1; m_rdata = 32'h0000_0042;
    settle(); chk("tmo_ok_cdout", c_dout, 32'h42); tick();
    m_done = 1'b0; m_rdata = '0;
    settle(); chk("tmo_err_sticky", err, 1'b1); tick();

    // watchdog: m_done arrives in the 8th busy cycle
    do_reset();
    l_req = 1'b1; l_addr = 32'h500;
    settle(); tick();
    l_req = 1'b0; l_addr = '0;
    for (int k = 1; k <= 7; k++) begin settle(); tick(); end
    m_done = 1'b1; m_rdata = 32'h0BAD_F00D;
    settle(); chk("tie_ldone", l_done, 1'b1); chk("tie_lrdata", l_rdata, 32'h0BAD_F00D); tick();
    m_done = 1'b0; m_rdata = '0;
    settle(); chk("tie_err", err, 1'b0); tick();

    // reset during BUSY_C
    c_load = 1'b1; c_addr = 32'h700;
    settle(); tick();
    c_load = 1'b0; c_addr = '0;
    settle(); chk("rb_busy_load", m_load, 1'b1); tick();
    rstn = 1'b0;
    settle(); chk("rb_load_async", m_load, 1'b0); chk("rb_cdone", c_done, 1'b0);
    tick();
    rstn = 1'b1;
    c_load = 1'b1; c_addr = 32'h800; l_req = 1'b1; l_addr = 32'h900;
    settle(); tick();
    idle_inputs();
    settle(); chk("rb_core_wins", m_addr, 32'h800); tick();
    m_done = 1'b1; settle(); tick();
    m_done = 1'b0; settle(); tick();

    // randomized traffic with occasional resets and varying completion rates
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 500) % 3 == 0) ? 60 : ((i / 500) % 3 == 1) ? 20 : 5;
      rstn    = ($urandom_range(0, 399) != 0);
      c_load  = $urandom_range(0, 1);
      c_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      c_addr  = $urandom;
      c_din   = $urandom;
      l_req   = $urandom_range(0, 1);
      l_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      l_addr  = $urandom;
      l_wdata = $urandom;
      m_rdata = $urandom;
      m_done  = ($urandom_range(0, 99) < thr);
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
